approx_mul_error_monitor: RTL and testbench



---
 rtl/approx_mul_error_monitor.sv | 186 ++++++++++++++++++
 tb/tb_approx_mul_error_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_error_monitor.sv
// Error-statistics accumulator for an approximate multiplier under test.
// Each accepted sample is checked against the exact product, and the block keeps saturating running sums of the error.
module approx_mul_error_monitor #(
  parameter int W  = 8,
  parameter int F  = 16,
  parameter int CW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [2*W-1:0]      p_apx,
  output logic                out_valid,
  output logic [CW-1:0]       n_samples,
  output logic [CW-1:0]       n_err,
  output logic [2*W+CW:0]     sum_ed,
  output logic [2*W+CW-1:0]   sum_aed,
  output logic [2*W-1:0]      max_aed,
  output logic [F+4+CW-1:0]   sum_re,
  output logic                sat,
  output logic [1:0]          dbg_state
);

  localparam int PW   = 2 * W;
  localparam int Q    = PW + F;
  localparam int EW   = PW + 1;
  localparam int SEW  = PW + CW + 1;
  localparam int SAW  = PW + CW;
  localparam int REW  = F + 4;
  localparam int SRW  = F + 4 + CW;
  localparam int CNTW = $clog2(Q + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]   exact_r;
  logic [EW-1:0]   ed_r;
  logic [PW-1:0]   aed_r;
  logic [REW-1:0]  re_r;
  logic [PW-1:0]   rem_r;
  logic [Q-2:0]    quo_r;
  logic [Q-1:0]    dvd_r;
  logic [CNTW-1:0] cnt;

  // Handshake: a sample transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is low while a sample is in flight
  // and during rst/clear, so clear always wins over a simultaneous transfer.
  logic take;
  assign in_ready  = (state == IDLE) && !clear && !rst;
  assign take      = in_valid && in_ready;
  assign dbg_state = state;

  logic [PW-1:0] prod;
  logic [EW-1:0] ed_in;
  logic [PW-1:0] aed_in;

  always_comb begin
    prod   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    ed_in  = {1'b0, prod} - {1'b0, p_apx};
    aed_in = ed_in[PW] ? (p_apx - prod) : ed_in[PW-1:0];
  end

  // Restoring division step; the partial remainder is always below the divisor,
  // so the borrow of the trial subtraction is the inverted quotient bit.
  logic [EW-1:0] rem_shift;
  logic [EW-1:0] rem_sub;
  logic          ge;
  logic [PW-1:0] rem_next;
  logic [Q-1:0]  quo_next;
  logic          re_over;
  logic          div_last;

  always_comb begin
    rem_shift = {rem_r, dvd_r[Q-1]};
    rem_sub   = rem_shift - {1'b0, exact_r};
    ge        = ~rem_sub[PW];
    rem_next  = ge ? rem_sub[PW-1:0] : rem_shift[PW-1:0];
    quo_next  = {quo_r, ge};
    re_over   = |quo_next[Q-1:REW];
    div_last  = (cnt == CNTW'(Q - 1));
  end

  logic [CW:0]    ns_sum;
  logic [CW:0]    ne_sum;
  logic [SAW:0]   sa_sum;
  logic [SRW:0]   sr_sum;
  logic [SEW-1:0] ed_ext;
  logic [SEW-1:0] se_sum;
  logic [SEW-1:0] se_clamp;
  logic           se_ovf;
  logic           acc_sat;

  always_comb begin
    ns_sum   = {1'b0, n_samples} + (CW + 1)'(1);
    ne_sum   = {1'b0, n_err} + {{CW{1'b0}}, (ed_r != '0)};
    sa_sum   = {1'b0, sum_aed} + {{(CW + 1){1'b0}}, aed_r};
    sr_sum   = {1'b0, sum_re} + {{(CW + 1){1'b0}}, re_r};
    ed_ext   = {{CW{ed_r[PW]}}, ed_r};
    se_sum   = sum_ed + ed_ext;
    se_ovf   = (sum_ed[SEW-1] == ed_ext[SEW-1]) && (se_sum[SEW-1] != sum_ed[SEW-1]);
    se_clamp = ed_ext[SEW-1] ? {1'b1, {(SEW - 1){1'b0}}} : {1'b0, {(SEW - 1){1'b1}}};
    acc_sat  = ns_sum[CW] | ne_sum[CW] | sa_sum[SAW] | sr_sum[SRW] | se_ovf;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (take) state_next = (prod != '0) ? DIV : ACC;
      DIV:  if (div_last) state_next = ACC;
      ACC:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) state <= IDLE;
    else              state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exact_r   <= '0;
      ed_r      <= '0;
      aed_r     <= '0;
      re_r      <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvd_r     <= '0;
      cnt       <= '0;
      n_samples <= '0;
      n_err     <= '0;
      sum_ed    <= '0;
      sum_aed   <= '0;
      max_aed   <= '0;
      sum_re    <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            exact_r <= prod;
            ed_r    <= ed_in;
            aed_r   <= aed_in;
            re_r    <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvd_r   <= {aed_in, {F{1'b0}}};
            cnt     <= '0;
          end
        end
        DIV: begin
          rem_r <= rem_next;
          quo_r <= quo_next[Q-2:0];
          dvd_r <= {dvd_r[Q-2:0], 1'b0};
          cnt   <= cnt + CNTW'(1);
          if (div_last) begin
            re_r <= re_over ? {REW{1'b1}} : quo_next[REW-1:0];
            if (re_over) sat <= 1'b1;
          end
        end
        ACC: begin
          n_samples <= ns_sum[CW] ? {CW{1'b1}} : ns_sum[CW-1:0];
          n_err     <= ne_sum[CW] ? {CW{1'b1}} : ne_sum[CW-1:0];
          sum_aed   <= sa_sum[SAW] ? {SAW{1'b1}} : sa_sum[SAW-1:0];
          sum_re    <= sr_sum[SRW] ? {SRW{1'b1}} : sr_sum[SRW-1:0];
          sum_ed    <= se_ovf ? se_clamp : se_sum;
          if (aed_r > max_aed) max_aed <= aed_r;
          sat       <= sat | acc_sat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// Directed bench for approx_mul_error_monitor: hand-computed cumulative statistics are queued per sample
// and checked by an independent monitor whenever out_valid pulses.
module tb_approx_mul_error_monitor;

  localparam int W  = 8;
  localparam int F  = 16;
  localparam int CW = 32;
  localparam int LAT_DIV  = 2 * W + F + 1;
  localparam int LAT_ZERO = 1;

  logic                 clk;
  logic                 rst;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         a;
  logic [W-1:0]         b;
  logic [2*W-1:0]       p_apx;
  logic                 out_valid;
  logic [CW-1:0]        n_samples;
  logic [CW-1:0]        n_err;
  logic [2*W+CW:0]      sum_ed;
  logic [2*W+CW-1:0]    sum_aed;
  logic [2*W-1:0]       max_aed;
  logic [F+4+CW-1:0]    sum_re;
  logic                 sat;
  logic [1:0]           dbg_state;

  approx_mul_error_monitor #(.W(W), .F(F), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .p_apx     (p_apx),
    .out_valid (out_valid),
    .n_samples (n_samples),
    .n_err     (n_err),
    .sum_ed    (sum_ed),
    .sum_aed   (sum_aed),
    .max_aed   (max_aed),
    .sum_re    (sum_re),
    .sat       (sat),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint ns;
    longint ne;
    longint sed;
    longint saed;
    longint mx;
    longint sre;
    longint st;
    int     cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input longint ns, input longint ne, input longint sed,
                              input longint saed, input longint mx, input longint sre,
                              input longint st);
    exp_t e;
    e.ns = ns; e.ne = ne; e.sed = sed; e.saed = saed; e.mx = mx; e.sre = sre; e.st = st;
    e.cyc = 0;
    return e;
  endfunction

  task automatic check_stats(input string tag, input exp_t e);
    check({tag, "_n_samples"}, longint'(n_samples), e.ns);
    check({tag, "_n_err"}, longint'(n_err), e.ne);
    check({tag, "_sum_ed"}, longint'($signed(sum_ed)), e.sed);
    check({tag, "_sum_aed"}, longint'(sum_aed), e.saed);
    check({tag, "_max_aed"}, longint'(max_aed), e.mx);
    check({tag, "_sum_re"}, longint'(sum_re), e.sre);
    check({tag, "_sat"}, longint'(sat), e.st);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency_cycle", longint'(cyc), longint'(mon_e.cyc));
        check_stats("upd", mon_e);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic [2*W-1:0] tp, input exp_t e, input int lat,
                      input bit expect_out);
    int guard = 0;
    @(negedge clk);
    a = ta; b = tb_v; p_apx = tp; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (expect_out) begin
      e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("busy_in_ready", longint'(in_ready), 0);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", longint'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int ov;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0; p_apx = '0;

    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", longint'(in_ready), 1);
    check("post_rst_out_valid", longint'(out_valid), 0);
    check_stats("rst", mk(0, 0, 0, 0, 0, 0, 0));

    // exact product
    send(8'd3, 8'd5, 16'd15, mk(1, 0, 0, 0, 0, 0, 0), LAT_DIV, 1'b1);
    drain();
    // ed = +10, re = floor(10*65536/100) = 6553
    send(8'd10, 8'd10, 16'd90, mk(2, 1, 10, 10, 10, 6553, 0), LAT_DIV, 1'b1);
    drain();
    // zero exact product: ed = -5, no division
    send(8'd0, 8'd200, 16'd5, mk(3, 2, 5, 15, 10, 6553, 0), LAT_ZERO, 1'b1);
    drain();
    // re clamps to 2^20-1, ed = -65534
    send(8'd1, 8'd1, 16'd65535, mk(4, 3, -65529, 65549, 65534, 1055128, 1), LAT_DIV, 1'b1);
    drain();
    // largest exact product, error-free; sat stays sticky
    send(8'd255, 8'd255, 16'd65025, mk(5, 3, -65529, 65549, 65534, 1055128, 1), LAT_DIV, 1'b1);
    drain();
    // ed = +1000, re = floor(1000*65536/20000) = 3276
    send(8'd200, 8'd100, 16'd19000, mk(6, 4, -64529, 66549, 65534, 1058404, 1), LAT_DIV, 1'b1);
    drain();
    // over-estimate: ed = -7, re = floor(7*65536/63) = 7281
    send(8'd7, 8'd9, 16'd70, mk(7, 5, -64536, 66556, 65534, 1065685, 1), LAT_DIV, 1'b1);
    drain();

    // clear mid-division, with a competing sample on in_valid
    send(8'd10, 8'd10, 16'd90, mk(0, 0, 0, 0, 0, 0, 0), LAT_DIV, 1'b0);
    repeat (9) @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1; p_apx = 16'd3;
    #1 check("clear_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_clear_in_ready", longint'(in_ready), 1);
    check("post_clear_out_valid", longint'(out_valid), 0);
    check_stats("clr", mk(0, 0, 0, 0, 0, 0, 0));

    // clear while idle also blocks a presented sample
    clear = 1'b1; in_valid = 1'b1; a = 8'd2; b = 8'd3; p_apx = 16'd1;
    #1 check("idle_clear_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("clear_no_out_valid", longint'(ov), 0);
    check("clear_n_samples", longint'(n_samples), 0);

    send(8'd10, 8'd10, 16'd90, mk(1, 1, 10, 10, 10, 6553, 0), LAT_DIV, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
